psk_symbol_mapper: RTL and testbench

Streaming BPSK/QPSK symbol mapper for the text transmit chain, sitting between the channel encoder (Hamming or BCH) and the channel model. It accepts one N-bit codeword per valid/ready handshake and serialises it, LSB first, into signed I/Q symbols. The mode is selectable per codeword. Every symbol is registered and backpressure-safe, which replaces the old one-shot combinational 2-bit-per-bit packing.

---
 rtl/psk_symbol_mapper.sv | 159 +++++++++++++++
 tb/tb_psk_symbol_mapper.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper
// Streaming BPSK/QPSK mapper. Accepts one N-bit codeword per input handshake
// and serialises it LSB first into registered, signed I/Q symbols.
// Bit 0 maps to +1 and bit 1 maps to -1 (all-ones).
//
// State table
//   state | meaning
//   IDLE  | in_ready high, waiting for a codeword
//   SEND  | presenting symbols; advances on each output handshake
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : codeword handshake
//   in_data [N-1:0]     : codeword, bit 0 sent first
//   in_mode             : 0 = BPSK, 1 = QPSK, captured with the codeword
//   out_valid/out_ready : symbol handshake
//   out_i, out_q        : signed AMP_W-bit rail levels
//   out_last            : final symbol of the codeword
module psk_symbol_mapper #(
    parameter int N     = 12,
    parameter int AMP_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AMP_W-1:0] out_i,
    output logic [AMP_W-1:0] out_q,
    output logic             out_last
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_BPSK = CW'(N - 1);
    localparam logic [CW-1:0] LAST_QPSK = CW'((N + 1) / 2 - 1);
    localparam logic [AMP_W-1:0] LVL_POS  = AMP_W'(1);
    localparam logic [AMP_W-1:0] LVL_NEG  = '1;
    localparam logic [AMP_W-1:0] LVL_ZERO = '0;
    localparam bit N_ODD = (N % 2) == 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     shift_q, shift_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AMP_W-1:0] out_i_q, out_i_d;
    logic [AMP_W-1:0] out_q_q, out_q_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             in_hs;
    logic             out_hs;
    logic [N-1:0]     shift_nxt;
    logic [CW-1:0]    cnt_nxt;

    function automatic logic [AMP_W-1:0] level(input logic b);
        return b ? LVL_NEG : LVL_POS;
    endfunction

    // In QPSK with odd N the last symbol has no partner bit for Q, so the
    // quadrature rail is left silent rather than sending a padded +1.
    function automatic logic [AMP_W-1:0] sym_q(input logic mode, input logic b,
                                               input logic [CW-1:0] idx);
        if (!mode)
            return LVL_ZERO;
        if (N_ODD && (idx == LAST_QPSK))
            return LVL_ZERO;
        return level(b);
    endfunction

    function automatic logic is_last(input logic mode, input logic [CW-1:0] idx);
        return mode ? (idx == LAST_QPSK) : (idx == LAST_BPSK);
    endfunction

    assign in_ready  = (state_q == IDLE) && !rst;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        shift_nxt   = mode_q ? (shift_q >> 2) : (shift_q >> 1);
        cnt_nxt     = cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    shift_d     = in_data;
                    mode_d      = in_mode;
                    cnt_d       = '0;
                    out_i_d     = level(in_data[0]);
                    out_q_d     = sym_q(in_mode, in_data[1], '0);
                    out_last_d  = is_last(in_mode, '0);
                    out_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_i_d     = LVL_ZERO;
                        out_q_d     = LVL_ZERO;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        shift_d    = shift_nxt;
                        cnt_d      = cnt_nxt;
                        out_i_d    = level(shift_nxt[0]);
                        out_q_d    = sym_q(mode_q, shift_nxt[1], cnt_nxt);
                        out_last_d = is_last(mode_q, cnt_nxt);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_psk_symbol_mapper.sv
module tb_psk_symbol_mapper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_mode, out_ready, sel;
    logic [14:0] in_data;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_last;
    logic [1:0]  a_out_i, a_out_q;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_last;
    logic [3:0]  b_out_i, b_out_q;

    assign a_in_valid = in_valid & ~sel;
    assign b_in_valid = in_valid & sel;

    psk_symbol_mapper #(.N(12), .AMP_W(2)) u_dut12 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(in_data[11:0]), .in_mode(in_mode),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_i(a_out_i), .out_q(a_out_q), .out_last(a_out_last)
    );

    psk_symbol_mapper #(.N(15), .AMP_W(4)) u_dut15 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_i(b_out_i), .out_q(b_out_q), .out_last(b_out_last)
    );

    int obs_i, obs_q, obs_valid, obs_ready, obs_last;
    always_comb begin
        obs_i     = sel ? int'($signed(b_out_i)) : int'($signed(a_out_i));
        obs_q     = sel ? int'($signed(b_out_q)) : int'($signed(a_out_q));
        obs_valid = sel ? int'(b_out_valid) : int'(a_out_valid);
        obs_ready = sel ? int'(b_in_ready)  : int'(a_in_ready);
        obs_last  = sel ? int'(b_out_last)  : int'(a_out_last);
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: list of symbols a codeword should produce, as rail levels.
    int exp_i[$], exp_q[$], exp_l[$];

    function automatic int lvl(input logic b);
        return b ? -1 : 1;
    endfunction

    function automatic void model(input logic [14:0] d, input logic m, input int n);
        int nsym;
        exp_i.delete(); exp_q.delete(); exp_l.delete();
        nsym = m ? (n + 1) / 2 : n;
        for (int k = 0; k < nsym; k++) begin
            if (!m) begin
                exp_i.push_back(lvl(d[k]));
                exp_q.push_back(0);
            end else begin
                exp_i.push_back(lvl(d[2*k]));
                exp_q.push_back((2*k + 1 < n) ? lvl(d[2*k+1]) : 0);
            end
            exp_l.push_back(k == nsym - 1 ? 1 : 0);
        end
    endfunction

    // policy: 0 = ready always, 1 = ready pattern 1,0,0, 2 = random.
    // abort_after >= 0 stops (without handshaking) when that symbol is shown.
    task automatic send_cw(input logic s, input logic [14:0] d, input logic m,
                           input int policy, input int abort_after);
        int n, cnt, step, budget;
        logic rdy;
        n = s ? 15 : 12;
        cnt = 0; step = 0;
        sel = s;
        model(d, m, n);
        @(negedge clk);
        budget = 0;
        while (obs_ready != 1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("accept_ready", obs_ready, 1);
        in_data = d; in_mode = m; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Keep a different codeword pending upstream; it must be ignored.
        in_data = 15'($urandom); in_mode = 1'($urandom);
        budget = 0;
        while (cnt < exp_i.size() && budget < 200) begin
            @(negedge clk);
            budget++;
            check("out_valid", obs_valid, 1);
            check("in_ready_busy", obs_ready, 0);
            check("out_i", obs_i, exp_i[cnt]);
            check("out_q", obs_q, exp_q[cnt]);
            check("out_last", obs_last, exp_l[cnt]);
            if (cnt == abort_after) return;
            case (policy)
                0:       rdy = 1'b1;
                1:       rdy = (step % 3) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            step++;
            out_ready = rdy;
            if (rdy) begin
                cnt++;
                if (cnt == exp_i.size()) in_valid = 1'b0;
            end
        end
        check("handshakes", cnt, exp_i.size());
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_valid", obs_valid, 0);
        check("idle_ready", obs_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sel = 1'b0;
        in_data = 15'h2A5A; in_mode = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", obs_ready, 0);
            check("rst_out_valid", obs_valid, 0);
            check("rst_out_i", obs_i, 0);
            check("rst_out_q", obs_q, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", obs_ready, 1);
        check("post_rst_valid", obs_valid, 0);

        send_cw(1'b0, 15'h001,  1'b0, 0, -1);
        send_cw(1'b0, 15'h006,  1'b1, 0, -1);
        send_cw(1'b1, 15'h7FFF, 1'b1, 0, -1);
        send_cw(1'b0, 15'h555,  1'b0, 1, -1);

        // Reset while the fourth QPSK symbol is on the bus.
        send_cw(1'b0, 15'h9C3, 1'b1, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", obs_valid, 0);
        check("midrst_ready", obs_ready, 0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_idle_ready", obs_ready, 1);
        check("midrst_idle_valid", obs_valid, 0);
        send_cw(1'b0, 15'h000, 1'b1, 0, -1);

        for (int t = 0; t < 24; t++) begin
            send_cw(1'($urandom_range(0, 1)), 15'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
